// File: rtl/wave_buffer_ctrl.sv
// wave_buffer_ctrl: capture controller for the 512-entry double-buffered
// waveform RAM. It arms on a rising zero crossing of the sample stream and
// writes 256 samples into the half the display is not reading. It then flips
// read_index during display blanking so the display shows the new capture.
module wave_buffer_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        wave_display_idle,
  output logic [8:0]  write_address,
  output logic        write_enable,
  output logic [7:0]  write_sample,
  output logic        read_index
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] count;
  logic       prev_neg;

  // Capture sequencer: crossing detection, RAM writes and buffer flip, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARMED;
      count         <= 8'd0;
      prev_neg      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= 9'd0;
      write_sample  <= 8'd0;
      read_index    <= 1'b0;
    end else begin
      // NOTE: write_enable defaults low each cycle so it is a one-cycle strobe;
      // address and data are left alone and hold their last values.
      write_enable <= 1'b0;

      // The sign history tracks every strobe, whatever the state.
      // NOTE: non-blocking assignment means the case below still sees the
      // previous sample's sign in this same cycle.
      if (new_sample_ready) begin
        prev_neg <= new_sample_in[15];
      end

      case (state)
        ARMED: begin
          // A rising zero crossing is a negative sample followed by a non-negative one.
          // The crossing sample itself is not captured.
          if (new_sample_ready && prev_neg && !new_sample_in[15]) begin
            state <= ACTIVE;
            count <= 8'd0;
          end
        end

        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            // Signed upper byte to unsigned: invert the sign bit (offset by +128).
            write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
            count         <= count + 8'd1;
            if (count == 8'd255) begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          // Flip only while the display is blanking, so it never tears mid-frame.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end

        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_buffer_ctrl.sv
// Self-checking bench for wave_buffer_ctrl. It runs directed scenarios and
// then randomized traffic. Every output is compared each cycle against a
// behavioural model of the capture rules.
module tb_wave_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'd0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_buffer_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  // Reference model: 0 = waiting for crossing, 1 = capturing, 2 = capture done.
  int m_phase  = 0;
  int m_filled = 0;
  int m_prev   = 0;
  int m_ri     = 0;
  int m_we     = 0;
  int m_addr   = 0;
  int m_data   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic rdy, input logic [15:0] d, input logic idle, input logic rst);
    int s;
    reset             = rst;
    new_sample_ready  = rdy;
    new_sample_in     = d;
    wave_display_idle = idle;
    s = $signed(d);
    if (rst) begin
      m_phase = 0; m_filled = 0; m_prev = 0; m_ri = 0;
      m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_phase == 0) begin
        if (rdy && m_prev == 1 && s >= 0) begin
          m_phase  = 1;
          m_filled = 0;
        end
      end else if (m_phase == 1) begin
        if (rdy) begin
          m_we     = 1;
          m_addr   = (m_ri == 1 ? 0 : 256) + m_filled;
          m_data   = (s + 32768) / 256;
          m_filled = m_filled + 1;
          if (m_filled == 256) m_phase = 2;
        end
      end else begin
        if (idle) begin
          m_ri    = 1 - m_ri;
          m_phase = 0;
        end
      end
      if (rdy) m_prev = (s < 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    if (write_enable === 1'b1) n_writes++;
    check("write_enable", {31'd0, write_enable}, m_we);
    check("read_index", {31'd0, read_index}, m_ri);
    if (m_we == 1) begin
      check("write_address", {23'd0, write_address}, m_addr);
      check("write_sample", {24'd0, write_sample}, m_data);
    end else begin
      // Held values are also tracked by the model.
      check("write_address_hold", {23'd0, write_address}, m_addr);
      check("write_sample_hold", {24'd0, write_sample}, m_data);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic gap();
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int w0;
    logic [15:0] bb [4];
    logic [7:0]  bb_exp [4];
    bb[0] = 16'h8000; bb[1] = 16'h0000; bb[2] = 16'h7FFF; bb[3] = 16'hFF00;
    bb_exp[0] = 8'h00; bb_exp[1] = 8'h80; bb_exp[2] = 8'hFF; bb_exp[3] = 8'h7F;

    // Reset for two cycles: every output at zero.
    cycle(1'b0, 16'd0, 1'b0, 1'b1);
    cycle(1'b0, 16'd0, 1'b0, 1'b1);
    check("reset_we", {31'd0, write_enable}, 32'd0);
    check("reset_addr", {23'd0, write_address}, 32'd0);
    check("reset_data", {24'd0, write_sample}, 32'd0);
    check("reset_ri", {31'd0, read_index}, 32'd0);

    // Positive sample right after reset does not trigger, nor do same-sign runs.
    w0 = n_writes;
    strobe(16'h0100); gap();
    strobe(16'h2000); gap();
    strobe(16'h7000); gap();
    strobe(16'hC000); gap();
    strobe(16'hD000); gap();
    check("no_false_trigger", n_writes - w0, 32'd0);

    // Trigger: negative, crossing, then first captured sample.
    strobe(16'hF000); gap();
    strobe(16'h0200);
    check("crossing_no_write", {31'd0, write_enable}, 32'd0);
    gap();
    strobe(16'h1234);
    check("first_we", {31'd0, write_enable}, 32'd1);
    check("first_addr", {23'd0, write_address}, 32'h100);
    check("first_data", {24'd0, write_sample}, 32'h92);

    // Back-to-back strobes at consecutive offsets.
    for (int i = 0; i < 4; i++) begin
      strobe(bb[i]);
      check("b2b_we", {31'd0, write_enable}, 32'd1);
      check("b2b_addr", {23'd0, write_address}, 32'h101 + i);
      check("b2b_data", {24'd0, write_sample}, {24'd0, bb_exp[i]});
    end

    // Finish the capture with a ramp (251 more writes) while the display is busy.
    for (int i = 5; i < 256; i++) begin
      strobe(16'(i * 256));
      if (i % 3 == 0) gap();
    end
    check("last_addr", {23'd0, write_address}, 32'h1FF);
    check("capture_count", n_writes - w0, 32'd256);
    strobe(16'h4000);
    check("257th_no_write", {31'd0, write_enable}, 32'd0);
    check("ri_held", {31'd0, read_index}, 32'd0);
    gap();
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    check("flip_ri", {31'd0, read_index}, 32'd1);

    // Second capture goes to the lower half; abandon it with a reset at write 100.
    strobe(16'h8000);
    strobe(16'h0000);
    strobe(16'h0100);
    check("second_addr0", {23'd0, write_address}, 32'h000);
    for (int i = 1; i < 100; i++) strobe(16'($urandom));
    check("mid_addr", {23'd0, write_address}, 32'd99);
    cycle(1'b1, 16'h1111, 1'b0, 1'b1);
    check("reset_cycle_we", {31'd0, write_enable}, 32'd0);
    check("reset_mid_ri", {31'd0, read_index}, 32'd0);
    strobe(16'h2222);
    check("post_reset_we", {31'd0, write_enable}, 32'd0);
    strobe(16'hA000);
    strobe(16'h0010);
    strobe(16'h3300);
    check("restart_addr", {23'd0, write_address}, 32'h100);
    check("restart_data", {24'd0, write_sample}, 32'hB3);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 16'($urandom),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1499) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
